// File: rtl/usadd_ctrl_pkg.sv
// Shared definitions for the uSADD job sequencer: default widths and FSM state encodings.
package usadd_ctrl_pkg;

    localparam int DEF_BW      = 4;
    localparam int DEF_ADD_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/usadd_ctrl_ustream_gen.sv
// ustream_gen: rate-codes two binary operands into unary bitstreams of length 2^BW.
// Optional macro USADD_CTRL_BITREV_EN bit-reverses the stream B comparison key so
// stream B is decorrelated from stream A; the ones count per stream is unchanged.
module ustream_gen
    import usadd_ctrl_pkg::*;
#(
    parameter int BW = DEF_BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    input  logic [BW-1:0] level_a,
    input  logic [BW-1:0] level_b,
    output logic          str_a,
    output logic          str_b,
    output logic          last_cycle
);

    logic [BW-1:0] cnt;
    logic [BW-1:0] key;

    // Stream position counter: zeroed before a job, steps once per RUN cycle and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + BW'(1);
        end
    end

`ifdef USADD_CTRL_BITREV_EN
    // Comparison key for stream B is the bit-reversed position, spreading its ones out.
    always_comb begin
        key = '0;
        for (int i = 0; i < BW; i++) begin
            key[i] = cnt[BW-1-i];
        end
    end
`else
    assign key = cnt;
`endif

    // Registered stream bits; both fall to zero as soon as the RUN window ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str_a <= 1'b0;
            str_b <= 1'b0;
        end else begin
            str_a <= run && (cnt < level_a);
            str_b <= run && (key < level_b);
        end
    end

    assign last_cycle = run && (cnt == {BW{1'b1}});

endmodule

// File: rtl/usadd_ctrl.sv
// usadd_ctrl: job sequencer for one unary scaled adder. Captures an operand pair, clears
// the adder, streams both operands for 2^BW cycles, drains the adder pipeline, and returns
// the counted carry ones, which equal floor((A+B)/2).
// Optional macro USADD_CTRL_BITREV_EN (in ustream_gen) decorrelates stream B.
module usadd_ctrl
    import usadd_ctrl_pkg::*;
#(
    parameter int BW      = DEF_BW,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iValid,
    output logic          oReady,
    input  logic [BW-1:0] iA,
    input  logic [BW-1:0] iB,
    output logic          oAddRstN,
    output logic          oStrA,
    output logic          oStrB,
    input  logic          iStrC,
    output logic          oValid,
    input  logic          iReady,
    output logic [BW-1:0] oSum,
    output logic          oBusy
);

    // The drain window covers the stream register stage plus the adder latency.
    localparam int DRAIN_W = $clog2(ADD_LAT + 2);

    state_t               state;
    logic [BW-1:0]        reg_a;
    logic [BW-1:0]        reg_b;
    logic [BW-1:0]        ones_cnt;
    logic [BW-1:0]        ones_next;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 last_cycle;
    logic                 gen_clear;
    logic                 gen_run;

    assign gen_clear = (state == ST_CLR);
    assign gen_run   = (state == ST_RUN);

    // Running carry count including the adder output bit seen this cycle.
    always_comb begin
        ones_next = ones_cnt + BW'(iStrC);
    end

    ustream_gen #(
        .BW(BW)
    ) u_stream (
        .clk        (iClk),
        .rst        (iRst),
        .clear      (gen_clear),
        .run        (gen_run),
        .level_a    (reg_a),
        .level_b    (reg_b),
        .str_a      (oStrA),
        .str_b      (oStrB),
        .last_cycle (last_cycle)
    );

    // Job FSM with registered handshake/status outputs, drain timer and ones counter.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            reg_a     <= '0;
            reg_b     <= '0;
            ones_cnt  <= '0;
            drain_cnt <= '0;
            oReady    <= 1'b1;
            oValid    <= 1'b0;
            oSum      <= '0;
            oAddRstN  <= 1'b1;
            oBusy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iValid && oReady) begin
                        reg_a    <= iA;
                        reg_b    <= iB;
                        oReady   <= 1'b0;
                        oBusy    <= 1'b1;
                        oAddRstN <= 1'b0;
                        state    <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    ones_cnt  <= '0;
                    drain_cnt <= '0;
                    oAddRstN  <= 1'b1;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    ones_cnt <= ones_next;
                    if (last_cycle) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    ones_cnt <= ones_next;
                    if (drain_cnt == DRAIN_W'(ADD_LAT)) begin
                        drain_cnt <= '0;
                        oSum      <= ones_next;
                        oValid    <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                        oBusy  <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    oValid   <= 1'b0;
                    oReady   <= 1'b1;
                    oBusy    <= 1'b0;
                    oAddRstN <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usadd_ctrl.sv
// Bench for usadd_ctrl wrapped with a behavioural uSADD (parallel counter + accumulator,
// two register stages). Expected sums are hand-computed or floor((A+B)/2).
module tb_usadd_ctrl;

    localparam int BW = 4;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [BW-1:0] i_a;
    logic [BW-1:0] i_b;
    logic          o_add_rstn;
    logic          o_str_a;
    logic          o_str_b;
    logic          str_c;
    logic          o_valid;
    logic          i_ready;
    logic [BW-1:0] o_sum;
    logic          o_busy;

    int total = 0;
    int bad   = 0;

    // Clock and cycle bookkeeping for the back-to-back period measurement.
    int cyc    = 0;
    int acc_n  = 0;
    int acc_cyc [0:7];
    bit mon_en = 0;

    usadd_ctrl #(
        .BW      (BW),
        .ADD_LAT (2)
    ) dut (
        .iClk     (clk),
        .iRst     (rst),
        .iValid   (i_valid),
        .oReady   (o_ready),
        .iA       (i_a),
        .iB       (i_b),
        .oAddRstN (o_add_rstn),
        .oStrA    (o_str_a),
        .oStrB    (o_str_b),
        .iStrC    (str_c),
        .oValid   (o_valid),
        .iReady   (i_ready),
        .oSum     (o_sum),
        .oBusy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural uSADD: stage 1 counts input ones, stage 2 accumulates and emits carries.
    logic [1:0] pc;
    logic       res;
    logic [1:0] acc_sum;
    assign acc_sum = {1'b0, res} + pc;

    always @(posedge clk or posedge rst) begin
        if (rst || !o_add_rstn) begin
            pc    <= 2'd0;
            res   <= 1'b0;
            str_c <= 1'b0;
        end else begin
            pc    <= {1'b0, o_str_a} + {1'b0, o_str_b};
            str_c <= acc_sum[1];
            res   <= acc_sum[0];
        end
    end

    // Records the cycle of every accepted handshake while monitoring is enabled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_en && i_valid && o_ready) begin
            if (acc_n < 8) acc_cyc[acc_n] <= cyc;
            acc_n <= acc_n + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Submits one job and waits for its result, tallying stream ones on the way.
    task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                 output logic [BW-1:0] sum, output int ones_a,
                                 output int ones_b, output bit got);
        int guard;
        ones_a = 0;
        ones_b = 0;
        got    = 0;
        guard  = 0;
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        guard   = 0;
        while (!o_valid && guard < 200) begin
            ones_a += int'(o_str_a);
            ones_b += int'(o_str_b);
            @(negedge clk);
            guard++;
        end
        got = o_valid;
        sum = o_sum;
    endtask

    logic [BW-1:0] sum;
    int            ones_a;
    int            ones_b;
    bit            got;
    bit            seen_valid;
    int            guard;

    logic [BW-1:0] dir_a [0:4] = '{4'd12, 4'd15, 4'd0, 4'd7, 4'd9};
    logic [BW-1:0] dir_b [0:4] = '{4'd4,  4'd15, 4'd0, 4'd0, 4'd6};
    int            dir_e [0:4] = '{8, 15, 0, 3, 7};

    logic [BW-1:0] b2b_a [0:2] = '{4'd3, 4'd10, 4'd14};
    logic [BW-1:0] b2b_b [0:2] = '{4'd5, 4'd13, 4'd1};
    int            b2b_e [0:2] = '{4, 11, 7};

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", int'(o_ready), 1);
        checkOutput("rst_valid", int'(o_valid), 0);
        checkOutput("rst_sum", int'(o_sum), 0);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_addrstn", int'(o_add_rstn), 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed jobs with hand-computed results.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(dir_a[i], dir_b[i], sum, ones_a, ones_b, got);
            checkOutput($sformatf("dir%0d_valid", i), int'(got), 1);
            checkOutput($sformatf("dir%0d_sum", i), int'(sum), dir_e[i]);
            if (i == 0) begin
                checkOutput("onesA_12", ones_a, 12);
                checkOutput("onesB_4", ones_b, 4);
            end
            @(negedge clk);
        end

        // Reset pulse in the middle of a RUN window.
        i_a     = 4'd15;
        i_b     = 4'd15;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        checkOutput("clr_addrstn", int'(o_add_rstn), 0);
        repeat (8) @(negedge clk);
        checkOutput("run_busy", int'(o_busy), 1);
        checkOutput("run_ready", int'(o_ready), 0);
        checkOutput("run_strA", int'(o_str_a), 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", int'(o_ready), 1);
        checkOutput("mid_rst_valid", int'(o_valid), 0);
        checkOutput("mid_rst_sum", int'(o_sum), 0);
        checkOutput("mid_rst_addrstn", int'(o_add_rstn), 1);
        checkOutput("mid_rst_strA", int'(o_str_a), 0);
        checkOutput("mid_rst_strB", int'(o_str_b), 0);
        checkOutput("mid_rst_busy", int'(o_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_valid) seen_valid = 1;
        end
        checkOutput("no_valid_after_rst", int'(seen_valid), 0);

        // Backpressure: result held in DONE while downstream stalls.
        i_ready = 1'b0;
        applyStimulus(4'd9, 4'd6, sum, ones_a, ones_b, got);
        checkOutput("bp_valid_seen", int'(got), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("bp_valid", int'(o_valid), 1);
            checkOutput("bp_sum", int'(o_sum), 7);
            checkOutput("bp_ready", int'(o_ready), 0);
        end
        i_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", int'(o_valid), 0);
        checkOutput("bp_release_ready", int'(o_ready), 1);

        // Back-to-back: iValid held high across three jobs.
        mon_en  = 1;
        i_a     = b2b_a[0];
        i_b     = b2b_b[0];
        i_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            guard = 0;
            while (!o_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            checkOutput($sformatf("b2b%0d_sum", j), int'(o_sum), b2b_e[j]);
            if (j < 2) begin
                i_a = b2b_a[j+1];
                i_b = b2b_b[j+1];
            end else begin
                i_valid = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        mon_en = 0;
        checkOutput("b2b_accepts", acc_n, 3);
        checkOutput("b2b_period1", acc_cyc[1] - acc_cyc[0], 22);
        checkOutput("b2b_period2", acc_cyc[2] - acc_cyc[1], 22);

        // Full operand sweep against floor((A+B)/2).
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(BW'(a), BW'(b), sum, ones_a, ones_b, got);
                checkOutput($sformatf("sweep_%0d_%0d_valid", a, b), int'(got), 1);
                checkOutput($sformatf("sweep_%0d_%0d", a, b), int'(sum), (a + b) / 2);
                if (!got) break;
                @(negedge clk);
            end
            if (!got) break;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
